// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE-array bus controller: FSM encoding,
// default bus widths and a one-hot decode helper.
package pe_array_pkg;

  localparam int DEFAULT_ID_WIDTH   = 8;
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int ONEHOT_MAX         = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Callers truncate the result to their own vector width.
  function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx);
    logic [ONEHOT_MAX-1:0] one;
    one = {{(ONEHOT_MAX-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search begins one slot after ptr
// and the first active request found receives a one-hot grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  localparam int PW = $clog2(N);

  logic          found;
  logic [PW-1:0] sel;
  int            idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      sel = PW'(idx);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_bus_scheduler.sv
// Broadcast-bus controller for the router row: programs router IDs one at a
// time, then round-robin arbitrates packet requesters onto the shared bus.
module pe_bus_scheduler
  import pe_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ID_WIDTH   = DEFAULT_ID_WIDTH,
  parameter int NUM_PE     = 16,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_start,
  input  logic                          cfg_valid,
  input  logic [ID_WIDTH-1:0]           cfg_id,
  output logic                          cfg_ready,
  output logic                          cfg_done,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ID_WIDTH-1:0]   req_src_id,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          config_state,
  output logic [NUM_PE-1:0]             ce,
  output logic [ID_WIDTH-1:0]           dest_id,
  output logic [ID_WIDTH-1:0]           source_id,
  output logic [DATA_WIDTH-1:0]         bus_data_in,
  output logic                          bus_data_valid,
  output logic                          busy,
  output logic [1:0]                    fsm_state
);

  localparam int CW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int PW = $clog2(NUM_REQ);

  // Handshake: a word/beat transfers in any cycle where valid && ready are
  // both high on the rising edge; ready never depends on registered data.
  state_t              state, state_n;
  logic [CW-1:0]       cnt;
  logic [PW-1:0]       rr, lock_idx, win_idx;
  logic                locked, cfg_pend, cfg_pend_n;
  logic                cfg_acc, cfg_last, accept, beat_last;
  logic [NUM_REQ-1:0]  grant;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr),
    .grant (grant)
  );

  assign busy      = (state == ST_CFG) || locked;
  assign fsm_state = state;

  always_comb begin
    cfg_ready = (state == ST_CFG);
    cfg_acc   = cfg_valid && cfg_ready;
    cfg_last  = cfg_acc && (cnt == CW'(NUM_PE - 1));

    // A pending reconfiguration suppresses any fresh grant on that cycle.
    req_ready = '0;
    if (state == ST_RUN) begin
      if (locked) begin
        req_ready = NUM_REQ'(onehot(32'(lock_idx)));
      end else if (!cfg_start) begin
        req_ready = grant;
      end
    end

    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_ready[k]) win_idx = PW'(k);
    end
    accept    = |(req_valid & req_ready);
    beat_last = accept && req_last[win_idx];

    state_n = state;
    case (state)
      ST_IDLE: if (cfg_start) state_n = ST_CFG;
      ST_CFG:  if (cfg_last) state_n = ST_RUN;
      ST_RUN: begin
        if ((!locked && cfg_start) || (beat_last && (cfg_pend || cfg_start)))
          state_n = ST_CFG;
      end
      default: state_n = ST_IDLE;
    endcase

    cfg_pend_n = (state == ST_RUN) && (state_n == ST_RUN) &&
                 (cfg_pend || (locked && cfg_start));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      rr             <= PW'(NUM_REQ - 1);
      lock_idx       <= '0;
      locked         <= 1'b0;
      cfg_pend       <= 1'b0;
      cfg_done       <= 1'b0;
      config_state   <= 1'b0;
      ce             <= '0;
      dest_id        <= '0;
      source_id      <= '0;
      bus_data_in    <= '0;
      bus_data_valid <= 1'b0;
    end else begin
      state          <= state_n;
      cfg_pend       <= cfg_pend_n;
      cfg_done       <= cfg_last;
      bus_data_valid <= accept;

      if (accept) begin
        bus_data_in <= req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
        source_id   <= req_src_id[int'(win_idx)*ID_WIDTH +: ID_WIDTH];
        if (req_last[win_idx]) begin
          locked <= 1'b0;
          rr     <= win_idx;
        end else begin
          locked   <= 1'b1;
          lock_idx <= win_idx;
        end
      end

      if (state_n == ST_CFG && state != ST_CFG) begin
        cnt <= '0;
      end else if (cfg_acc) begin
        cnt <= cnt + CW'(1);
      end

      // Router-facing outputs follow the state being left this cycle, so the
      // last config word is still visible in the first RUN cycle.
      case (state)
        ST_IDLE: begin
          config_state <= (state_n == ST_CFG);
          ce           <= '0;
        end
        ST_CFG: begin
          config_state <= 1'b1;
          if (cfg_acc) begin
            ce      <= NUM_PE'(onehot(32'(cnt)));
            dest_id <= cfg_id;
          end else begin
            ce <= '0;
          end
        end
        ST_RUN: begin
          if (state_n == ST_CFG) begin
            config_state <= 1'b1;
            ce           <= '0;
          end else begin
            config_state <= 1'b0;
            ce           <= '1;
          end
        end
        default: begin
          config_state <= 1'b0;
          ce           <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_bus_scheduler.sv
// Bench for pe_bus_scheduler: config vector table, directed arbitration
// sequences and random traffic against a transaction-level reference model.
module tb_pe_bus_scheduler;

  localparam int DW  = 16;
  localparam int IDW = 8;
  localparam int NPE = 16;
  localparam int NR  = 4;
  localparam int M_IDLE = 0;
  localparam int M_CFG  = 1;
  localparam int M_RUN  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start, cfg_valid;
  logic [IDW-1:0]    cfg_id;
  logic              cfg_ready, cfg_done;
  logic [NR-1:0]     req_valid, req_last, req_ready;
  logic [NR*IDW-1:0] req_src_id;
  logic [NR*DW-1:0]  req_data;
  logic              config_state;
  logic [NPE-1:0]    ce;
  logic [IDW-1:0]    dest_id, source_id;
  logic [DW-1:0]     bus_data_in;
  logic              bus_data_valid, busy;
  logic [1:0]        fsm_state;

  pe_bus_scheduler #(.DATA_WIDTH(DW), .ID_WIDTH(IDW), .NUM_PE(NPE), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_id(cfg_id), .cfg_ready(cfg_ready), .cfg_done(cfg_done),
    .req_valid(req_valid), .req_src_id(req_src_id), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .config_state(config_state),
    .ce(ce), .dest_id(dest_id), .source_id(source_id),
    .bus_data_in(bus_data_in), .bus_data_valid(bus_data_valid),
    .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int errors = 0;
  int checks = 0;
  logic [IDW+DW-1:0] exp_q[$];
  logic [IDW-1:0]    req_ids[NR];
  logic [DW-1:0]     cur_data[NR];
  int m_mode, m_owner, m_last;
  bit m_pend;

  typedef struct {
    logic           start;
    logic           valid;
    logic [IDW-1:0] id;
    logic           exp_rdy;
    logic [NPE-1:0] exp_ce;
    logic [IDW-1:0] exp_dest;
    logic           exp_cs;
    logic           exp_done;
    logic [1:0]     exp_state;
  } cfg_vec_t;
  cfg_vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_owner = -1;
    m_last  = NR - 1;
    m_pend  = 0;
    exp_q.delete();
  endtask

  task automatic drive_req(input logic [NR-1:0] v, input logic [NR-1:0] l);
    req_valid = v;
    req_last  = l;
    for (int i = 0; i < NR; i++) begin
      req_src_id[i*IDW +: IDW] = req_ids[i];
      req_data[i*DW +: DW]     = cur_data[i];
    end
  endtask

  // One RUN-phase cycle: predict ready and transfers from the arbitration
  // rules, then check the registered bus/router outputs after the edge.
  task automatic cycle(input logic [NR-1:0] v, input logic [NR-1:0] l, input logic cs,
                       output int acc, output logic [NR-1:0] rdy);
    logic [NR-1:0] exp_rdy;
    int win, j, m0;
    drive_req(v, l);
    cfg_start = cs;
    #1;
    rdy = req_ready;
    m0 = m_mode;
    exp_rdy = '0;
    win = -1;
    if (m_mode == M_RUN) begin
      if (m_owner >= 0) exp_rdy[m_owner] = 1'b1;
      else if (!cs) begin
        for (int k = 1; k <= NR; k++) begin
          j = (m_last + k) % NR;
          if (win < 0 && v[j]) win = j;
        end
        if (win >= 0) exp_rdy[win] = 1'b1;
      end
    end
    check("req_ready", req_ready, exp_rdy);
    acc = -1;
    for (int k = 0; k < NR; k++) if (exp_rdy[k] && v[k]) acc = k;
    if (acc >= 0) exp_q.push_back({req_ids[acc], cur_data[acc]});
    if (m_mode == M_RUN) begin
      if (m_owner < 0 && cs) m_mode = M_CFG;
      else if (m_owner >= 0 && cs) m_pend = 1;
      if (acc >= 0) begin
        if (l[acc]) begin
          m_owner = -1;
          m_last  = acc;
          if (m_pend) begin
            m_mode = M_CFG;
            m_pend = 0;
          end
        end else m_owner = acc;
      end
    end
    @(posedge clk); #1;
    cfg_start = 1'b0;
    check("bus_valid", bus_data_valid, acc >= 0);
    if (acc >= 0 && exp_q.size() > 0) check("bus_beat", {source_id, bus_data_in}, exp_q.pop_front());
    check("state", fsm_state, m_mode);
    check("busy", busy, (m_mode == M_CFG) || (m_owner >= 0));
    if (m0 == M_RUN) begin
      check("ce_run", ce, (m_mode == M_CFG) ? '0 : {NPE{1'b1}});
      check("cfgst_run", config_state, m_mode == M_CFG);
    end else if (m0 == M_CFG) begin
      check("ce_cfg_idle", ce, 0);
      check("cfgst_cfg", config_state, 1);
    end
    if (acc >= 0) cur_data[acc] = DW'($urandom);
  endtask

  task automatic quick_config(input bit need_start);
    int done_cnt;
    done_cnt = 0;
    drive_req('0, '0);
    if (need_start) begin
      cfg_start = 1'b1;
      cfg_valid = 1'b0;
      @(posedge clk); #1;
      cfg_start = 1'b0;
    end
    for (int i = 0; i < NPE; i++) begin
      cfg_valid = 1'b1;
      cfg_id = IDW'(8'h30 + i);
      @(posedge clk); #1;
      if (cfg_done) done_cnt++;
    end
    cfg_valid = 1'b0;
    check("qcfg_done_count", done_cnt, 1);
    check("qcfg_state", fsm_state, M_RUN);
    check("qcfg_ce", ce, 1 << (NPE - 1));
    check("qcfg_dest", dest_id, 8'h3F);
    m_mode  = M_RUN;
    m_owner = -1;
    m_pend  = 0;
  endtask

  function automatic cfg_vec_t mk(input logic s, input logic v, input logic [IDW-1:0] id,
                                  input logic r, input logic [NPE-1:0] c, input logic [IDW-1:0] d,
                                  input logic cs, input logic dn, input logic [1:0] st);
    cfg_vec_t e;
    e.start = s; e.valid = v; e.id = id; e.exp_rdy = r; e.exp_ce = c;
    e.exp_dest = d; e.exp_cs = cs; e.exp_done = dn; e.exp_state = st;
    return e;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    int rem[NR];
    logic [NR-1:0] rdy, v, l;
    logic [IDW-1:0] last_dest;
    logic [NR-1:0] lk_v[8];
    logic [NR-1:0] lk_l[8];
    logic [NR-1:0] one_bit;

    for (int i = 0; i < NR; i++) begin
      req_ids[i]  = IDW'(8'h50 + 7*i);
      cur_data[i] = DW'($urandom);
    end
    cfg_start = 0; cfg_valid = 0; cfg_id = '0;
    drive_req('0, '0);
    model_reset();

    // Config table: start, 16 words with gaps after words 3 and 9, one RUN cycle.
    last_dest = '0;
    vecs.push_back(mk(1, 0, 8'h00, 0, '0, last_dest, 1, 0, 2'd1));
    for (int i = 0; i < NPE; i++) begin
      one_bit = '0;
      vecs.push_back(mk(0, 1, IDW'(8'h10 + i), 1, NPE'(1) << i, IDW'(8'h10 + i), 1,
                        i == NPE - 1, (i == NPE - 1) ? 2'd2 : 2'd1));
      last_dest = IDW'(8'h10 + i);
      if (i == 3 || i == 9) vecs.push_back(mk(i == 9, 0, 8'hEE, 1, '0, last_dest, 1, 0, 2'd1));
    end
    vecs.push_back(mk(0, 0, 8'h00, 0, {NPE{1'b1}}, last_dest, 0, 0, 2'd2));

    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ce", ce, 0);
    check("rst_cfgst", config_state, 0);
    check("rst_bus_valid", bus_data_valid, 0);
    check("rst_bus_data", {source_id, bus_data_in, dest_id}, 0);
    check("rst_done_busy_ready", {cfg_done, busy, cfg_ready, req_ready}, 0);
    check("rst_state", fsm_state, M_IDLE);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < vecs.size(); k++) begin
      cfg_start = vecs[k].start;
      cfg_valid = vecs[k].valid;
      cfg_id    = vecs[k].id;
      #1;
      check("cfg_ready", cfg_ready, vecs[k].exp_rdy);
      @(posedge clk); #1;
      check("cfg_ce", ce, vecs[k].exp_ce);
      check("cfg_dest", dest_id, vecs[k].exp_dest);
      check("cfg_config_state", config_state, vecs[k].exp_cs);
      check("cfg_done", cfg_done, vecs[k].exp_done);
      check("cfg_state", fsm_state, vecs[k].exp_state);
    end
    cfg_start = 0; cfg_valid = 0;
    m_mode = M_RUN;

    // Fairness: every requester always has a single-beat packet waiting.
    for (int k = 0; k < 8; k++) begin
      cycle('1, '1, 0, acc, rdy);
      check("fair_grant", rdy, 4'b0001 << (k % NR));
    end

    // Packet lock: req1 single beat moves the pointer, then req2 5-beat with a 2-cycle stall.
    cycle(4'b0010, 4'b0010, 0, acc, rdy);
    lk_v = '{4'b0101, 4'b0101, 4'b0001, 4'b0001, 4'b0101, 4'b0101, 4'b0101, 4'b0001};
    lk_l = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0101, 4'b0001};
    for (int k = 0; k < 8; k++) begin
      cycle(lk_v[k], lk_l[k], 0, acc, rdy);
      if (k < 7) check("lock_req0_blocked", rdy[0], 0);
    end
    check("lock_then_req0", rdy, 4'b0001);

    // Deferred reconfig: cfg_start on beat 2 of a 4-beat packet from req1.
    cycle(4'b1011, 4'b1001, 0, acc, rdy);
    cycle(4'b1011, 4'b1001, 1, acc, rdy);
    check("defer_still_locked", busy, 1);
    cycle(4'b1011, 4'b1001, 0, acc, rdy);
    cycle(4'b1011, 4'b1011, 0, acc, rdy);
    check("defer_in_cfg", fsm_state, M_CFG);
    cycle(4'b1011, 4'b1011, 0, acc, rdy);
    check("defer_no_grant", rdy, 0);
    quick_config(0);

    // Reset mid-packet: req3 sends beats 1-2, reset lands during beat 3.
    cycle(4'b1000, 4'b0000, 0, acc, rdy);
    cycle(4'b1000, 4'b0000, 0, acc, rdy);
    drive_req(4'b1000, 4'b0000);
    rst = 1'b1;
    #1;
    check("rst_async_bus_valid", bus_data_valid, 0);
    @(posedge clk); #1;
    check("midrst_bus_valid", bus_data_valid, 0);
    check("midrst_ce", ce, 0);
    check("midrst_state", fsm_state, M_IDLE);
    check("midrst_ready", req_ready, 0);
    rst = 1'b0;
    drive_req('0, '0);
    model_reset();
    @(posedge clk); #1;
    quick_config(1);
    cycle('1, '1, 0, acc, rdy);
    check("post_rst_grant", rdy, 4'b0001);

    // Random traffic with random packet lengths and valid gaps.
    for (int i = 0; i < NR; i++) rem[i] = $urandom_range(1, 4);
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NR; i++) begin
        v[i] = ($urandom_range(0, 3) != 0);
        l[i] = (rem[i] == 1);
      end
      cycle(v, l, 0, acc, rdy);
      if (acc >= 0) begin
        rem[acc]--;
        if (rem[acc] == 0) rem[acc] = $urandom_range(1, 4);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
